// File: rtl/sm_product_accumulator.sv
// sm_product_accumulator: sums a burst of sign-magnitude products into a saturating
// sign-magnitude dot-product result, with valid/ready handshakes on both sides.
module sm_product_accumulator #(
  parameter int PROD_W = 7,
  parameter int ACC_W  = 11,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int MAG_W  = PROD_W - 1;
  localparam int WIDEST = (ACC_W > PROD_W) ? ACC_W : PROD_W;
  // Two guard bits so a single add can never wrap before it is clamped.
  localparam int SUM_W  = WIDEST + 2;

  typedef logic signed [ACC_W:0]   acc_t;
  typedef logic signed [SUM_W-1:0] wide_t;

  localparam wide_t SAT_MAX = wide_t'((1 << (ACC_W - 1)) - 1);
  localparam wide_t SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    CONVERT = 2'd2,
    OUT     = 2'd3
  } state_t;

  function automatic wide_t apply_prod(input wide_t acc, input logic [PROD_W-1:0] prod);
    wide_t mag;
    mag = wide_t'(prod[MAG_W-1:0]);
    if (prod[PROD_W-1]) begin
      apply_prod = acc - mag;
    end else begin
      apply_prod = acc + mag;
    end
  endfunction

  function automatic logic is_over(input wide_t v);
    is_over = (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic wide_t clamp(input wide_t v);
    if (v > SAT_MAX) begin
      clamp = SAT_MAX;
    end else if (v < SAT_MIN) begin
      clamp = SAT_MIN;
    end else begin
      clamp = v;
    end
  endfunction

  // Zero has a clear sign bit, so negative zero cannot be produced here.
  function automatic logic [ACC_W-1:0] to_sm(input acc_t a);
    acc_t mag;
    if (a[ACC_W]) begin
      mag = -a;
    end else begin
      mag = a;
    end
    to_sm = {a[ACC_W], mag[ACC_W-2:0]};
  endfunction

  state_t            state_r;
  acc_t              acc_r;
  logic              ovf_r;
  logic [LEN_W-1:0]  remaining_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [ACC_W-1:0]  out_sum_r;
  logic              out_ovf_r;
  logic              busy_r;

  logic              accept_s;
  wide_t             next_sum_s;
  logic              sat_s;
  acc_t              acc_next_s;

  // Next accumulator value for the product on the input, clamped to the result range.
  always_comb begin
    accept_s   = in_valid & in_ready_r;
    next_sum_s = apply_prod(wide_t'(acc_r), in_prod);
    sat_s      = is_over(next_sum_s);
    acc_next_s = acc_t'(clamp(next_sum_s));
  end

  // Burst control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      ovf_r       <= 1'b0;
      remaining_r <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_ovf_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            remaining_r <= len;
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b1;
            if (len != '0) begin
              state_r    <= ACCUM;
              in_ready_r <= 1'b1;
            end else begin
              state_r    <= CONVERT;
              in_ready_r <= 1'b0;
            end
          end else begin
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            acc_r       <= acc_next_s;
            ovf_r       <= ovf_r | sat_s;
            remaining_r <= remaining_r - LEN_W'(1);
            if (remaining_r == LEN_W'(1)) begin
              state_r    <= CONVERT;
              in_ready_r <= 1'b0;
            end else begin
              state_r    <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        CONVERT: begin
          out_sum_r <= to_sm(acc_r);
          out_ovf_r <= ovf_r;
          state_r   <= OUT;
        end
        OUT: begin
          // First OUT cycle raises out_valid; the handshake is taken from then on.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_ovf   = out_ovf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sm_product_accumulator.sv
// Self-checking bench for sm_product_accumulator: directed cases plus random bursts
// against an integer reference model, on a default and an ACC_W=7 instance.
module tb_sm_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start7 = 1'b0;
  logic [3:0]  len = 4'd0;
  logic        in_valid = 1'b0;
  logic [6:0]  in_prod = 7'd0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf, busy;
  logic [10:0] out_sum;
  logic        in_ready7, out_valid7, out_ovf7, busy7;
  logic [6:0]  out_sum7;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [6:0] prods [16];
  logic       sel_r = 1'b0;

  logic        c_in_ready, c_out_valid, c_out_ovf, c_busy;
  logic [31:0] c_out_sum;

  assign c_in_ready  = sel_r ? in_ready7  : in_ready;
  assign c_out_valid = sel_r ? out_valid7 : out_valid;
  assign c_out_ovf   = sel_r ? out_ovf7   : out_ovf;
  assign c_busy      = sel_r ? busy7      : busy;
  assign c_out_sum   = sel_r ? 32'(out_sum7) : 32'(out_sum);

  always #5 clk = ~clk;

  sm_product_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );

  sm_product_accumulator #(.ACC_W(7)) dut7 (
    .clk(clk), .rst(rst), .start(start7), .len(len),
    .in_valid(in_valid), .in_ready(in_ready7), .in_prod(in_prod),
    .out_valid(out_valid7), .out_ready(out_ready),
    .out_sum(out_sum7), .out_ovf(out_ovf7), .busy(busy7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer running sum, clamped to +/-(2^(accw-1)-1) after each add.
  task automatic model(input int n, input int accw, output int es, output int eo);
    int s, mx, m;
    mx = (1 << (accw - 1)) - 1;
    s  = 0;
    eo = 0;
    for (int k = 0; k < n; k++) begin
      m = int'(prods[k][5:0]);
      if (prods[k][6]) s = s - m;
      else             s = s + m;
      if (s > mx) begin
        s = mx; eo = 1;
      end else if (s < -mx) begin
        s = -mx; eo = 1;
      end
    end
    es = (s < 0) ? ((1 << (accw - 1)) + (-s)) : s;
  endtask

  task automatic set_start(input logic v);
    if (sel_r) start7 = v;
    else       start  = v;
  endtask

  task automatic run_burst(input int n, input int gap_at, input int gap_len,
                           input bit rnd_gaps, input int hold, input bit junk_at_start);
    int  i, cyc, gap, es, eo;
    bit  hole;
    model(n, sel_r ? 7 : 11, es, eo);
    len = 4'(n);
    if (junk_at_start) begin
      in_valid = 1'b1;
      in_prod  = 7'h3f;
    end else begin
      in_valid = 1'b0;
    end
    set_start(1'b1);
    tick();
    set_start(1'b0);
    in_valid = 1'b0;
    check("busy_after_start", 32'(c_busy), 32'd1);
    check("in_ready_after_start", 32'(c_in_ready), 32'(n != 0));
    i = 0; cyc = 0; gap = 0;
    while (i < n && cyc < 500) begin
      hole = (i == gap_at) && (gap < gap_len);
      if (hole) gap++;
      if (rnd_gaps && $urandom_range(0, 2) == 0) hole = 1'b1;
      in_valid = !hole;
      in_prod  = hole ? 7'($urandom) : prods[i];
      check("in_ready_in_accum", 32'(c_in_ready), 32'd1);
      if (!hole && c_in_ready) i++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("accept_count", 32'(i), 32'(n));
    tick();
    check("lat_edge1_out_valid", 32'(c_out_valid), 32'd0);
    tick();
    check("lat_edge2_out_valid", 32'(c_out_valid), 32'd1);
    check("out_sum", c_out_sum, 32'(es));
    check("out_ovf", 32'(c_out_ovf), 32'(eo));
    check("in_ready_in_out", 32'(c_in_ready), 32'd0);
    check("busy_in_out", 32'(c_busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      set_start(1'b1);
      tick();
      check("hold_out_valid", 32'(c_out_valid), 32'd1);
      check("hold_out_sum", c_out_sum, 32'(es));
      check("hold_out_ovf", 32'(c_out_ovf), 32'(eo));
      check("hold_busy", 32'(c_busy), 32'd1);
    end
    set_start(1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_dropped", 32'(c_out_valid), 32'd0);
    check("busy_idle", 32'(c_busy), 32'd0);
    check("out_sum_kept", c_out_sum, 32'(es));
  endtask

  initial begin
    bit saw_valid;

    // Reset for two cycles: every output low on both instances.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst7_outputs", {27'd0, in_ready7, out_valid7, out_ovf7, busy7, |out_sum7}, 32'd0);

    // Mixed signs, back-to-back valid: -6 + 30 + 12 = +36.
    sel_r = 1'b0;
    prods[0] = 7'b1000110; prods[1] = 7'b0011110; prods[2] = 7'b0001100;
    run_burst(3, -1, 0, 1'b0, 0, 1'b0);
    check("t2_sum_literal", 32'(out_sum), 32'd36);

    // Two negatives with a 2-cycle gap: -55 in sign-magnitude.
    prods[0] = 7'b1000110; prods[1] = 7'b1110001;
    run_burst(2, 1, 2, 1'b0, 0, 1'b0);
    check("t3_sum_literal", 32'(out_sum), 32'(11'b1_0000110111));

    // Cancellation must give +0, and an input negative zero adds nothing.
    prods[0] = 7'b0000101; prods[1] = 7'b1000101;
    run_burst(2, -1, 0, 1'b0, 0, 1'b0);
    prods[0] = 7'b1000000;
    run_burst(1, -1, 0, 1'b0, 0, 1'b1);

    // Empty burst, then a held result with ignored start pulses.
    run_burst(0, -1, 0, 1'b0, 3, 1'b0);

    // Narrow accumulator: 63 + 63 saturates at 63, then -10 gives 53 with ovf.
    sel_r = 1'b1;
    prods[0] = 7'b0111111; prods[1] = 7'b0111111; prods[2] = 7'b1001010;
    run_burst(3, -1, 0, 1'b0, 1, 1'b0);
    check("t6_sum_literal", 32'(out_sum7), 32'(7'b0110101));
    check("t6_ovf_literal", 32'(out_ovf7), 32'd1);

    // Reset after one accepted product abandons the burst.
    len = 4'd3;
    start7 = 1'b1;
    tick();
    start7 = 1'b0;
    in_valid = 1'b1;
    in_prod = 7'b0010100;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy7), 32'd0);
    check("midrst_in_ready", 32'(in_ready7), 32'd0);
    check("midrst_out_sum", 32'(out_sum7), 32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid7) saw_valid = 1'b1;
    end
    check("midrst_no_out_valid", 32'(saw_valid), 32'd0);

    // Random bursts on both widths, with random input gaps and output stalls.
    for (int r = 0; r < 24; r++) begin
      int n;
      sel_r = (r >= 12);
      n = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) prods[k] = 7'($urandom_range(0, 127));
      run_burst(n, -1, 0, 1'b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
